// File: rtl/alarm_dismiss_challenge.sv
// alarm_dismiss_challenge: random button-sequence alarm dismissal; CHALLENGE_TIMEOUT_EN adds an inactivity timeout
module alarm_dismiss_challenge #(
  parameter int NUM_BTN = 4,
  parameter int BTN_W = $clog2(NUM_BTN),
  parameter int SEQ_LEN = 4,
  parameter int RAND_W = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset_n,
  input  logic [RAND_W-1:0]            i_Random_Num,
  input  logic                         i_Alarm_Active,
  input  logic [NUM_BTN-1:0]           i_Buttons,
  output logic [BTN_W-1:0]             o_Target_Btn,
  output logic [$clog2(SEQ_LEN+1)-1:0] o_Progress,
  output logic                         o_Busy,
  output logic                         o_Dismiss,
  output logic                         o_Error
);
  localparam int SEQ_W = SEQ_LEN * BTN_W;
  localparam int PW = $clog2(SEQ_LEN + 1);
  localparam int IW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BTN_W-1:0] target_q, target_d;
  logic [PW-1:0] progress_q, progress_d;
  logic busy_q, busy_d, dismiss_q, dismiss_d, error_q, error_d;
  logic timeout, act, hit, miss, start, last;
`ifdef CHALLENGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1) && i_Buttons == '0;
  assign cnt_d = (state_q != ACTIVE || i_Buttons != '0 || timeout) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  assign act = state_q == ACTIVE && i_Alarm_Active;
  assign hit = i_Buttons == (NUM_BTN'(1) << target_q);
  assign miss = act && ((i_Buttons != '0 && !hit) || timeout);
  assign start = state_q == IDLE && i_Alarm_Active;
  assign last = idx_q == IW'(SEQ_LEN - 1);
  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    idx_d = idx_q;
    target_d = target_q;
    progress_d = progress_q;
    busy_d = busy_q;
    dismiss_d = 1'b0;
    error_d = 1'b0;
    if (start || miss) begin
      state_d = ACTIVE;
      seq_d = i_Random_Num[SEQ_W-1:0];
      idx_d = '0;
      target_d = i_Random_Num[BTN_W-1:0];
      progress_d = '0;
      busy_d = 1'b1;
      error_d = miss;
    end else if (act && hit && last) begin
      state_d = DONE;
      busy_d = 1'b0;
      dismiss_d = 1'b1;
      progress_d = PW'(SEQ_LEN);
    end else if (act && hit) begin
      idx_d = idx_q + 1'b1;
      progress_d = progress_q + 1'b1;
      target_d = seq_q[(int'(idx_q) + 1) * BTN_W +: BTN_W];
    end else if (state_q != IDLE && !i_Alarm_Active) begin
      state_d = IDLE;
      idx_d = '0;
      target_d = '0;
      progress_d = '0;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state_q <= IDLE;
      seq_q <= '0;
      idx_q <= '0;
      target_q <= '0;
      progress_q <= '0;
      busy_q <= 1'b0;
      dismiss_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      idx_q <= idx_d;
      target_q <= target_d;
      progress_q <= progress_d;
      busy_q <= busy_d;
      dismiss_q <= dismiss_d;
      error_q <= error_d;
    end
  assign o_Target_Btn = target_q;
  assign o_Progress = progress_q;
  assign o_Busy = busy_q;
  assign o_Dismiss = dismiss_q;
  assign o_Error = error_q;
endmodule

// File: tb/tb_alarm_dismiss_challenge.sv
// tb_alarm_dismiss_challenge: randomized self-checking bench against a queue-based model
module tb_alarm_dismiss_challenge;
  logic clk = 1'b0, rst_n = 1'b0, alarm = 1'b0;
  logic [7:0] rnd = '0;
  logic [3:0] btn = '0;
  logic [1:0] o_Target_Btn;
  logic [2:0] o_Progress;
  logic o_Busy, o_Dismiss, o_Error;
  int total = 0, bad = 0;
  int m_state = 0, m_cnt = 0;
  int q[$];
  bit m_dis = 0, m_err = 0;
  alarm_dismiss_challenge #(.NUM_BTN(4), .SEQ_LEN(4), .RAND_W(8), .TIMEOUT_CYCLES(16)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Random_Num(rnd), .i_Alarm_Active(alarm), .i_Buttons(btn),
    .o_Target_Btn(o_Target_Btn), .o_Progress(o_Progress), .o_Busy(o_Busy),
    .o_Dismiss(o_Dismiss), .o_Error(o_Error)
  );
  always #5 clk = ~clk;
  function void model_reset();
    m_state = 0;
    m_cnt = 0;
    m_dis = 0;
    m_err = 0;
    q.delete();
  endfunction
  function void load(logic [7:0] r);
    q.delete();
    for (int d = 0; d < 4; d++) q.push_back(int'((r >> (2 * d)) & 8'h3));
    m_cnt = 0;
  endfunction
  function void model(logic [7:0] r, bit a, logic [3:0] b);
    bit to;
    m_dis = 0;
    m_err = 0;
    to = 0;
`ifdef CHALLENGE_TIMEOUT_EN
    to = m_state == 1 && a && b == 0 && m_cnt == 15;
`endif
    if (m_state == 0) begin
      if (a) begin
        load(r);
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (!a) begin
        m_state = 0;
        q.delete();
      end else if (b == 0 && !to) m_cnt++;
      else if ($countones(b) == 1 && b[q[0]]) begin
        m_cnt = 0;
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_state = 2;
          m_dis = 1;
        end
      end else begin
        m_err = 1;
        load(r);
      end
    end else if (!a) m_state = 0;
  endfunction
  function logic [7:0] exp_vec();
    int prog;
    prog = m_state == 1 ? 4 - q.size() : m_state == 2 ? 4 : 0;
    return {(m_state == 1) ? 2'(q[0]) : 2'd0, 3'(prog), m_state == 1, m_dis, m_err};
  endfunction
  function logic [7:0] act_vec();
    return {(m_state == 1) ? o_Target_Btn : 2'd0, o_Progress, o_Busy, o_Dismiss, o_Error};
  endfunction
  task automatic drive(input logic [7:0] r, input bit a, input logic [3:0] b);
    rnd = r;
    alarm = a;
    btn = b;
    @(posedge clk);
    model(r, a, b);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({o_Target_Btn, o_Progress, o_Busy, o_Dismiss, o_Error} !== 8'h0) begin
      bad++;
      $display("FAIL reset: got %b want 00000000", {o_Target_Btn, o_Progress, o_Busy, o_Dismiss, o_Error});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      drive(8'($urandom), 0, 4'($urandom));
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL idle_press%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_sequence();
    logic [3:0] presses [4] = '{4'h1, 4'h2, 4'h8, 4'h4};
    drive(8'hB4, 1, 0);
    total++;
    if (act_vec() !== exp_vec() || o_Target_Btn !== 2'd0) begin
      bad++;
      $display("FAIL seq_start: got %b want %b", act_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 1, presses[i]);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL seq_press%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    total++;
    if ({o_Dismiss, o_Busy, o_Progress} !== 5'b10100) begin
      bad++;
      $display("FAIL seq_dismiss: got %b want 10100", {o_Dismiss, o_Busy, o_Progress});
    end
    drive(8'($urandom), 1, 4'h1);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL seq_done_hold: got %b want %b", act_vec(), exp_vec());
    end
    drive(8'($urandom), 0, 0);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL seq_release: got %b want %b", act_vec(), exp_vec());
    end
  endtask
  task automatic test_wrong();
    drive(8'hB4, 1, 0);
    drive(8'($urandom), 1, 4'h1);
    drive(8'h1B, 1, 4'h4);
    total++;
    if (act_vec() !== exp_vec() || {o_Error, o_Target_Btn, o_Progress} !== 6'b111000) begin
      bad++;
      $display("FAIL wrong_press: got %b want %b", act_vec(), exp_vec());
    end
    drive(8'($urandom), 1, 4'h8);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL wrong_recovery: got %b want %b", act_vec(), exp_vec());
    end
    drive(8'h0, 0, 0);
  endtask
  task automatic test_multi();
    drive(8'hB4, 1, 0);
    drive(8'($urandom), 1, 4'b0011);
    total++;
    if (act_vec() !== exp_vec() || o_Error !== 1'b1) begin
      bad++;
      $display("FAIL multi_press: got %b want %b", act_vec(), exp_vec());
    end
    drive(8'h0, 0, 0);
  endtask
  task automatic test_abort();
    drive(8'hB4, 1, 0);
    drive(8'($urandom), 1, 4'h1);
    drive(8'($urandom), 1, 4'h2);
    drive(8'($urandom), 0, 4'h8);
    total++;
    if (act_vec() !== exp_vec() || {o_Progress, o_Busy, o_Dismiss, o_Error} !== 6'b0) begin
      bad++;
      $display("FAIL abort: got %b want %b", act_vec(), exp_vec());
    end
  endtask
  task automatic test_timeout();
    bit exp_e;
    drive(8'hB4, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(8'($urandom), 1, 0);
      exp_e = 0;
`ifdef CHALLENGE_TIMEOUT_EN
      exp_e = i == 16;
`endif
      total++;
      if (act_vec() !== exp_vec() || o_Error !== exp_e) begin
        bad++;
        $display("FAIL timeout_cyc%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    drive(8'h0, 0, 0);
  endtask
  task automatic test_random();
    logic [3:0] b;
    bit a;
    int sel;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom % 20) != 0;
      sel = $urandom % 4;
      b = sel < 2 ? 4'h0 : sel == 2 ? (m_state == 1 ? 4'(1 << q[0]) : 4'(1 << ($urandom % 4))) : 4'($urandom);
      drive(8'($urandom), a, b);
      total++;
      if (act_vec() !== exp_vec() || (o_Dismiss && o_Error)) begin
        bad++;
        $display("FAIL random%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_async_reset();
    drive(8'hB4, 1, 0);
    drive(8'($urandom), 1, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_Target_Btn, o_Progress, o_Busy, o_Dismiss, o_Error} !== 8'h0) begin
      bad++;
      $display("FAIL async_reset: got %b want 00000000", {o_Target_Btn, o_Progress, o_Busy, o_Dismiss, o_Error});
    end
    alarm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_wrong();
    test_multi();
    test_abort();
    test_timeout();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_dismiss_challenge.md
Name: alarm_dismiss_challenge

Overview:
Consumer of the free-running random-number counter. When the alarm fires, it samples the counter once to build a random button sequence. The user must press that sequence in order to dismiss the alarm. It sits between the random counter, the debounced button block and the alarm controller/display.

Parameters:
- NUM_BTN, 4, number of user buttons; must be a power of 2.
- BTN_W, $clog2(NUM_BTN), width of a button index.
- SEQ_LEN, 4, number of presses required; minimum 1.
- RAND_W, 8, width of the random input; must be >= SEQ_LEN*BTN_W.
- TIMEOUT_CYCLES, 1000000, inactivity limit; used only when the optional feature is compiled in.

Ports:
- i_Clk, input, 1: system clock.
- i_Reset_n, input, 1: asynchronous, active-low reset.
- i_Random_Num, input, RAND_W: free-running random value.
- i_Alarm_Active, input, 1: level signal, high while the alarm is sounding.
- i_Buttons, input, NUM_BTN: debounced, single-cycle press pulses; bit k = button k.
- o_Target_Btn, output, BTN_W: index of the button currently expected (display hint).
- o_Progress, output, $clog2(SEQ_LEN+1): number of correct presses so far.
- o_Busy, output, 1: challenge in progress.
- o_Dismiss, output, 1: one-cycle pulse when the sequence is completed.
- o_Error, output, 1: one-cycle pulse on a wrong press (or timeout).

Behaviour:
- Single clock. One clock domain.
- Reset (i_Reset_n low, asynchronous): state IDLE; sequence register, index, o_Target_Btn, o_Progress, o_Busy, o_Dismiss and o_Error all 0.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - When i_Alarm_Active=1 at a clock edge, capture the low SEQ_LEN*BTN_W bits of i_Random_Num into the sequence register, clear the index, go to ACTIVE.
  - o_Busy rises the cycle after that edge.
- Sequence mapping: digit d = seq[d*BTN_W +: BTN_W]; digit 0 is pressed first.
- o_Target_Btn = digit[index], registered; valid while o_Busy=1.
- ACTIVE, per clock edge:
  - i_Buttons == 0: no change.
  - Exactly one bit set, and its index equals the target:
    - If not the last digit: index+1, o_Progress+1.
    - If it is digit SEQ_LEN-1: go to DONE, pulse o_Dismiss for one cycle, o_Busy falls, o_Progress = SEQ_LEN.
  - Wrong index, or more than one bit set:
    - Pulse o_Error for one cycle.
    - Recapture i_Random_Num on the same edge; index and o_Progress return to 0; stay in ACTIVE.
- DONE: hold (no re-arm) until i_Alarm_Active=0, then go to IDLE and clear o_Progress. Button presses are ignored.
- i_Alarm_Active=0 in ACTIVE (alarm snoozed/cleared externally): go to IDLE next edge, clear index/o_Progress/o_Busy, no pulse.
- Simultaneous alarm drop and press in the same cycle: the alarm drop wins; the press is ignored.
- Latency: a press sampled at edge N is reflected in o_Progress/o_Dismiss/o_Error after edge N, i.e. visible in cycle N+1.
- o_Dismiss and o_Error are never high in the same cycle.
- Presses in IDLE are ignored.

Optional Feature:
- Macro: CHALLENGE_TIMEOUT_EN.
- Defined:
  - An inactivity counter runs in ACTIVE. It clears on any press, on recapture, and on entry to ACTIVE.
  - When it reaches TIMEOUT_CYCLES-1 with no press, the block behaves exactly as for a wrong press: o_Error pulse, recapture, index 0.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter is built, no timeout occurs, TIMEOUT_CYCLES is ignored.

Test Plan:
Defaults: NUM_BTN=4, SEQ_LEN=4, RAND_W=8.
- Reset released, i_Alarm_Active=0, buttons toggled -> all outputs stay 0, o_Busy=0.
- i_Random_Num=8'hB4, i_Alarm_Active rises -> sequence 0,1,3,2. Press bits 0,1,3,2 (one-hot 1,2,8,4) -> o_Target_Btn steps 0→1→3→2; o_Progress 1,2,3,4; o_Dismiss pulses once after the 4th press; o_Busy falls.
- Same start, presses 0 then button 2 (expected 1), while i_Random_Num=8'h1B at that edge -> o_Error one pulse; o_Progress=0; new sequence 3,2,1,0; o_Target_Btn=3.
- Same start, i_Buttons=4'b0011 -> treated as wrong: o_Error pulse, recapture.
- After 2 correct presses, drop i_Alarm_Active in the same cycle as a correct press -> IDLE; o_Progress=0; no o_Dismiss, no o_Error.
- With CHALLENGE_TIMEOUT_EN and TIMEOUT_CYCLES=16: no press for 16 cycles in ACTIVE -> o_Error pulse at cycle 16, index reset. Without the macro, the same stimulus -> no o_Error.
- Bonus: assert i_Reset_n low mid-ACTIVE -> all outputs 0 immediately, asynchronously.
